// File: rtl/fpu_add_normalize.sv
// FPU adder back end: effective add/subtract of aligned fractions, one-bit-per-cycle
// normalisation, truncating pack into an IEEE-754 word with zero/overflow/underflow flags.
module fpu_add_normalize #(
   parameter bit double = 1'b0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  sign_a,
   input  logic                                  sign_b,
   input  logic [(double ? 11 : 8)-1:0]          exp_large,
   input  logic [(double ? 52 : 23)+1:0]         frac_a_al,
   input  logic [(double ? 52 : 23)+1:0]         frac_b_al,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [(double ? 64 : 32)-1:0]         result,
   output logic                                  flag_zero,
   output logic                                  flag_ovf,
   output logic                                  flag_unf,
   output logic [1:0]                            o_dbg_state
);

   localparam int size     = double ? 64 : 32;
   localparam int exponent = double ? 11 : 8;
   localparam int mantissa = double ? 52 : 23;
   localparam int FW       = mantissa + 2;
   localparam logic [exponent-1:0] EXP_ONES = '1;
   localparam logic [exponent-1:0] EXP_ONE  = {{(exponent-1){1'b0}}, 1'b1};

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid and its payload never change while waiting for ready.
   typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_sign_a, r_sign_b;
   logic [FW-1:0]       r_frac_a, r_frac_b;
   logic                r_sign, w_sign_nxt;
   logic [exponent-1:0] r_exp, w_exp_nxt;
   logic [FW-1:0]       r_frac, w_frac_nxt;
   logic                r_zero, r_ovf, r_unf;
   logic                w_zero_nxt, w_ovf_nxt, w_unf_nxt;
   logic [FW-1:0]       w_sum;
   logic                w_sum_sign;
   logic [exponent-1:0] w_exp_inc;

   assign w_exp_inc = r_exp + 1'b1;

   // Magnitude add, or larger-minus-smaller so the difference is never negative.
   always_comb begin
      w_sum      = r_frac_a + r_frac_b;
      w_sum_sign = r_sign_a;
      if (r_sign_a != r_sign_b) begin
         if (r_frac_a >= r_frac_b) begin
            w_sum      = r_frac_a - r_frac_b;
            w_sum_sign = r_sign_a;
         end else begin
            w_sum      = r_frac_b - r_frac_a;
            w_sum_sign = r_sign_b;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_exp_nxt   = r_exp;
      w_frac_nxt  = r_frac;
      w_zero_nxt  = r_zero;
      w_ovf_nxt   = r_ovf;
      w_unf_nxt   = r_unf;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_exp_nxt   = exp_large;
               w_zero_nxt  = 1'b0;
               w_ovf_nxt   = 1'b0;
               w_unf_nxt   = 1'b0;
               w_state_nxt = ADD;
            end
         end
         ADD: begin
            w_sign_nxt = w_sum_sign;
            w_frac_nxt = w_sum;
            if (w_sum == '0) begin
               w_sign_nxt  = 1'b0;
               w_exp_nxt   = '0;
               w_zero_nxt  = 1'b1;
               w_state_nxt = DONE;
            end else if (w_sum[FW-1]) begin
               // Carry out: the dropped LSB is the truncation.
               w_state_nxt = DONE;
               if (w_exp_inc == EXP_ONES) begin
                  w_exp_nxt  = EXP_ONES;
                  w_frac_nxt = '0;
                  w_ovf_nxt  = 1'b1;
               end else begin
                  w_exp_nxt  = w_exp_inc;
                  w_frac_nxt = w_sum >> 1;
               end
            end else if (w_sum[mantissa]) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = NORM;
            end
         end
         NORM: begin
            if (r_exp <= EXP_ONE) begin
               // One more shift would need exponent 0: flush instead of going subnormal.
               w_exp_nxt   = '0;
               w_frac_nxt  = '0;
               w_unf_nxt   = 1'b1;
               w_state_nxt = DONE;
            end else begin
               w_exp_nxt  = r_exp - 1'b1;
               w_frac_nxt = r_frac << 1;
               if (r_frac[mantissa-1]) w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_frac_a <= '0;
         r_frac_b <= '0;
         r_sign   <= 1'b0;
         r_exp    <= '0;
         r_frac   <= '0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_sign_a <= sign_a;
            r_sign_b <= sign_b;
            r_frac_a <= frac_a_al;
            r_frac_b <= frac_b_al;
         end
         r_sign <= w_sign_nxt;
         r_exp  <= w_exp_nxt;
         r_frac <= w_frac_nxt;
         r_zero <= w_zero_nxt;
         r_ovf  <= w_ovf_nxt;
         r_unf  <= w_unf_nxt;
      end
   end

   assign result      = {r_sign, r_exp, r_frac[mantissa-1:0]};
   assign flag_zero   = r_zero;
   assign flag_ovf    = r_ovf;
   assign flag_unf    = r_unf;
   assign o_dbg_state = r_state;

   logic w_unused;
   assign w_unused = ^{size[0]};

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Self-checking bench for fpu_add_normalize (single precision): directed corner cases
// plus randomized operands checked against an arithmetic reference model.
module tb_fpu_add_normalize;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        sign_a = 1'b0, sign_b = 1'b0;
   logic [7:0]  exp_large = '0;
   logic [24:0] frac_a_al = '0, frac_b_al = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        flag_zero, flag_ovf, flag_unf;
   logic [1:0]  dbg_state;

   fpu_add_normalize #(.double(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sign_a(sign_a), .sign_b(sign_b), .exp_large(exp_large),
      .frac_a_al(frac_a_al), .frac_b_al(frac_b_al),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flags;   // {zero, ovf, unf}
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   holding = 1'b0;
   bit   rand_bp = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: value-level add, then place the leading one at bit 23.
   function automatic exp_t model(input bit sa, input bit sb, input int e,
                                  input logic [24:0] fa, input logic [24:0] fb);
      exp_t   r;
      longint mag;
      bit     s;
      int     p, k;
      r.res = '0; r.flags = '0; r.lat = 2; r.acc = 0;
      if (sa == sb)      begin mag = longint'(fa) + longint'(fb); s = sa; end
      else if (fa >= fb) begin mag = longint'(fa) - longint'(fb); s = sa; end
      else               begin mag = longint'(fb) - longint'(fa); s = sb; end
      if (mag == 0) begin
         r.flags = 3'b100;
         return r;
      end
      p = 0;
      for (int i = 0; i < 25; i++) if (mag[i]) p = i;
      if (p == 24) begin
         if (e + 1 == 255) begin
            r.res = {s, 8'hFF, 23'h0};
            r.flags = 3'b010;
         end else begin
            r.res = {s, 8'(e + 1), 23'(mag >> 1)};
         end
      end else begin
         k = 23 - p;
         if (k > 0 && e <= k) begin
            r.res = {s, 31'h0};
            r.flags = 3'b001;
            r.lat = 2 + ((e < 1) ? 1 : e);
         end else begin
            r.res = {s, 8'(e - k), 23'(mag << k)};
            r.lat = 2 + k;
         end
      end
      return r;
   endfunction

   task automatic send(input bit sa, input bit sb, input int e,
                       input logic [24:0] fa, input logic [24:0] fb);
      exp_t x;
      int   guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
      end else begin
         sign_a = sa; sign_b = sb; exp_large = 8'(e);
         frac_a_al = fa; frac_b_al = fb;
         in_valid = 1'b1;
         x = model(sa, sb, e, fa, fb);
         x.acc = cyc;
         exp_q.push_back(x);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_q.size() != 0 || holding) && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_timeout", 64'(exp_q.size() != 0 || holding), 64'd0);
   endtask

   task automatic set_ready(input bit v);
      @(posedge clk);
      #2 out_ready = v;
   endtask

   // Compare process: every cycle the result is presented.
   always @(negedge clk) begin
      if (!rst_n) begin
         holding = 1'b0;
      end else if (out_valid) begin
         if (!holding) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               cur = exp_q.pop_front();
               holding = 1'b1;
               chk("result", 64'(result), 64'(cur.res));
               chk("flags", 64'({flag_zero, flag_ovf, flag_unf}), 64'(cur.flags));
               chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            end
         end else begin
            chk("result_hold", 64'(result), 64'(cur.res));
            chk("flags_hold", 64'({flag_zero, flag_ovf, flag_unf}), 64'(cur.flags));
         end
         chk("in_ready_in_done", 64'(in_ready), 64'd0);
         if (out_ready) holding = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   exp_t m;
   logic [24:0] fa, fb;
   bit sa, sb;
   int e;

   initial begin
      // Model pins against hand-computed values.
      m = model(0, 0, 127, 25'h0800000, 25'h0800000);
      chk("model_1p1", 64'({m.res, m.flags}), 64'({32'h40000000, 3'b000}));
      m = model(0, 1, 127, 25'h0C00000, 25'h0800000);
      chk("model_1p5m1", 64'({m.res, 8'(m.lat)}), 64'({32'h3F000000, 8'd3}));
      m = model(0, 1, 2, 25'h0800001, 25'h0800000);
      chk("model_unf", 64'({m.res, m.flags}), 64'({32'h00000000, 3'b001}));

      repeat (3) @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out", 64'({out_valid, result, flag_zero, flag_ovf, flag_unf}), 64'd0);
      rst_n = 1'b1;

      send(0, 0, 127, 25'h0800000, 25'h0800000);  wait_idle();
      send(0, 1, 127, 25'h0C00000, 25'h0800000);  wait_idle();
      send(0, 1, 130, 25'h0A00000, 25'h0A00000);  wait_idle();
      send(0, 0, 254, 25'h0800000, 25'h0800000);  wait_idle();
      send(1, 1, 100, 25'h0FFFFFF, 25'h0000001);  wait_idle();

      // Underflow with downstream stalled for 5 cycles.
      set_ready(0);
      send(0, 1, 2, 25'h0800001, 25'h0800000);
      begin
         int guard = 0;
         while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      repeat (5) @(negedge clk);
      chk("bp_still_valid", 64'(out_valid), 64'd1);
      set_ready(1);
      @(negedge clk);
      @(negedge clk);
      chk("bp_valid_dropped", 64'(out_valid), 64'd0);
      wait_idle();

      // Reset taken mid-normalisation discards the operation.
      send(0, 1, 127, 25'h0C00000, 25'h0800000);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk("rst_mid_result", 64'(result), 64'd0);
      exp_q.delete();
      rst_n = 1'b1;
      send(0, 0, 127, 25'h0800000, 25'h0800000);  wait_idle();

      // Randomized operands with random downstream backpressure.
      rand_bp = 1'b1;
      for (int n = 0; n < 200; n++) begin
         sa = 1'($urandom_range(0, 1));
         sb = 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : $urandom_range(1, 254);
         fa = {2'b01, 23'($urandom)};
         fb = {2'b01, 23'($urandom)};
         case ($urandom_range(0, 3))
            0: fb = fb >> $urandom_range(0, 25);
            1: fa = fa >> $urandom_range(0, 25);
            2: fb = fa ^ 25'($urandom_range(0, 255));
            default: ;
         endcase
         send(sa, sb, e, fa, fb);
      end
      wait_idle();
      rand_bp = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
